// File: rtl/mix_add_char_unit.sv
// MIX arithmetic helper: one-cycle sign-magnitude ADD/SUB with overflow, and
// a 30-iteration double-dabble CHAR conversion to ten MIX digit codes.
// The two paths share nothing and can be busy at the same time.

// One BCD digit of the double-dabble shifter. A digit of 5 or more gets 3
// added so that the following left shift carries it into the next digit.
module mix_dabble_digit (
  input  logic [3:0] d,
  output logic [3:0] adj
);
  assign adj = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module mix_add_char_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        add_start,
  input  logic        subtract,
  input  logic [30:0] in1,
  input  logic [30:0] in2,
  output logic        add_stop,
  output logic [30:0] add_out,
  output logic        overflow,
  input  logic        char_start,
  input  logic [29:0] char_in,
  output logic        char_stop,
  output logic [59:0] char_out
);
  localparam int NUM_DIG = 10;

  // ---------------- ADD / SUB ----------------
  logic        s1, s2;
  logic [29:0] m1, m2;
  logic [30:0] sum;
  logic [29:0] d12, d21;
  logic [30:0] add_res;
  logic        add_ovf;

  // Sign-magnitude add. Equal magnitudes and wraps to zero keep in1's sign,
  // so a -0 operand pair yields -0.
  always_comb begin
    s1      = in1[30];
    s2      = in2[30] ^ subtract;
    m1      = in1[29:0];
    m2      = in2[29:0];
    sum     = {1'b0, m1} + {1'b0, m2};
    d12     = m1 - m2;
    d21     = m2 - m1;
    add_ovf = 1'b0;
    add_res = {s1, sum[29:0]};
    if (s1 == s2) begin
      add_res = {s1, sum[29:0]};
      add_ovf = sum[30];
    end else if (m1 >= m2) begin
      add_res = {s1, d12};
    end else begin
      add_res = {s2, d21};
    end
  end

  // Register the result on a start; it holds until the next start completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      add_stop <= 1'b0;
      add_out  <= '0;
      overflow <= 1'b0;
    end else begin
      add_stop <= add_start;
      if (add_start) begin
        add_out  <= add_res;
        overflow <= add_ovf;
      end
    end
  end

  // ---------------- CHAR ----------------
  logic [NUM_DIG-1:0][3:0] bcd;
  logic [NUM_DIG-1:0][3:0] adj;
  logic [NUM_DIG-1:0][3:0] nbcd;
  logic [NUM_DIG-1:0][5:0] code;
  logic [29:0]             bin;
  logic [29:0]             nbin;
  logic [4:0]              cnt;
  logic                    busy;

  assign busy = (cnt != 5'd0);

  genvar g;
  generate
    for (g = 0; g < NUM_DIG; g++) begin : g_dig
      mix_dabble_digit u_dig (
        .d   (bcd[g]),
        .adj (adj[g])
      );
      // Codes come from the post-shift digits so the last iteration's
      // result can be captured on the same edge.
      assign code[g] = 6'd30 + {2'b00, nbcd[g]};
    end
  endgenerate

  // Adjust-then-shift of the {bcd, bin} register pair by one bit.
  assign nbcd = {adj[NUM_DIG-1:0], bin[29]} >> 0 == 41'd0 ? '0 : 40'({adj, bin[29]});
  assign nbin = {bin[28:0], 1'b0};

  // Load on an idle start, then iterate 30 times; the final iteration
  // captures the codes and fires char_stop. Reset aborts silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 5'd0;
      bcd       <= '0;
      bin       <= '0;
      char_stop <= 1'b0;
      char_out  <= '0;
    end else begin
      char_stop <= 1'b0;
      if (!busy) begin
        if (char_start) begin
          bin <= char_in;
          bcd <= '0;
          cnt <= 5'd30;
        end
      end else begin
        bcd <= nbcd;
        bin <= nbin;
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          char_stop <= 1'b1;
          char_out  <= code;
        end
      end
    end
  end

endmodule

// File: tb/tb_mix_add_char_unit.sv
// Directed bench for mix_add_char_unit. Stimulus pushes hand-computed
// expectations (value plus due cycle) into queues; a negedge monitor pops
// and compares on each stop strobe and flags late or unexpected strobes.
module tb_mix_add_char_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        add_start, subtract;
  logic [30:0] in1, in2;
  logic        add_stop;
  logic [30:0] add_out;
  logic        overflow;
  logic        char_start;
  logic [29:0] char_in;
  logic        char_stop;
  logic [59:0] char_out;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [31:0] add_exp_q[$];
  int          add_cyc_q[$];
  logic [59:0] chr_exp_q[$];
  int          chr_cyc_q[$];

  mix_add_char_unit dut (
    .clk        (clk),
    .reset      (reset),
    .add_start  (add_start),
    .subtract   (subtract),
    .in1        (in1),
    .in2        (in2),
    .add_stop   (add_stop),
    .add_out    (add_out),
    .overflow   (overflow),
    .char_start (char_start),
    .char_in    (char_in),
    .char_stop  (char_stop),
    .char_out   (char_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare on strobes, flag strobes nobody asked for, and flag
  // expectations whose due cycle has passed without a strobe.
  always @(negedge clk) begin
    if (!reset) begin
      if (add_stop) begin
        compared++;
        if (add_exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL add_unexpected: add_stop at cycle %0d with no pending op", cyc);
        end else begin
          if ({overflow, add_out} !== add_exp_q[0] || cyc != add_cyc_q[0]) begin
            mismatched++;
            $display("FAIL add_result: got ovf=%0b out=%h @%0d, want ovf=%0b out=%h @%0d",
                     overflow, add_out, cyc, add_exp_q[0][31], add_exp_q[0][30:0], add_cyc_q[0]);
          end
          void'(add_exp_q.pop_front());
          void'(add_cyc_q.pop_front());
        end
      end else if (add_cyc_q.size() > 0 && cyc > add_cyc_q[0]) begin
        compared++;
        mismatched++;
        $display("FAIL add_timeout: no add_stop by cycle %0d (due %0d)", cyc, add_cyc_q[0]);
        void'(add_exp_q.pop_front());
        void'(add_cyc_q.pop_front());
      end

      if (char_stop) begin
        compared++;
        if (chr_exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL char_unexpected: char_stop at cycle %0d with no pending op", cyc);
        end else begin
          if (char_out !== chr_exp_q[0] || cyc != chr_cyc_q[0]) begin
            mismatched++;
            $display("FAIL char_result: got %h @%0d, want %h @%0d",
                     char_out, cyc, chr_exp_q[0], chr_cyc_q[0]);
          end
          void'(chr_exp_q.pop_front());
          void'(chr_cyc_q.pop_front());
        end
      end else if (chr_cyc_q.size() > 0 && cyc > chr_cyc_q[0]) begin
        compared++;
        mismatched++;
        $display("FAIL char_timeout: no char_stop by cycle %0d (due %0d)", cyc, chr_cyc_q[0]);
        void'(chr_exp_q.pop_front());
        void'(chr_cyc_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  // Issue one ADD/SUB in the next cycle; add_start stays high so repeated
  // calls are back-to-back. Call add_idle to drop the strobe.
  task automatic add_op(input logic sub, input logic [30:0] a, input logic [30:0] b,
                        input logic [30:0] want, input logic want_ovf);
    @(posedge clk); #1;
    add_start = 1'b1;
    subtract  = sub;
    in1       = a;
    in2       = b;
    add_exp_q.push_back({want_ovf, want});
    add_cyc_q.push_back(cyc + 1);
  endtask

  task automatic add_idle();
    @(posedge clk); #1;
    add_start = 1'b0;
  endtask

  // One-cycle char_start; expectation pushed only when a completion is due.
  task automatic char_op(input logic [29:0] v, input bit expect_done, input logic [59:0] want);
    @(posedge clk); #1;
    char_start = 1'b1;
    char_in    = v;
    if (expect_done) begin
      chr_exp_q.push_back(want);
      chr_cyc_q.push_back(cyc + 31);
    end
    @(posedge clk); #1;
    char_start = 1'b0;
  endtask

  task automatic wait_char_done();
    for (int i = 0; i < 60 && chr_cyc_q.size() > 0; i++) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; add_start = 1'b0; subtract = 1'b0; in1 = '0; in2 = '0;
    char_start = 1'b0; char_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_add_stop",  {63'd0, add_stop}, 64'd0);
    check("rst_char_stop", {63'd0, char_stop}, 64'd0);
    check("rst_add_out",   {33'd0, add_out}, 64'd0);
    check("rst_overflow",  {63'd0, overflow}, 64'd0);
    check("rst_char_out",  {4'd0, char_out}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // ADD/SUB directed vectors, issued back-to-back.
    add_op(1'b0, 31'h0000_0005, 31'h0000_0007, 31'h0000_000C, 1'b0); // +5 + +7
    add_op(1'b1, 31'h0000_0005, 31'h0000_0007, 31'h4000_0002, 1'b0); // +5 - +7
    add_op(1'b0, 31'h4000_0003, 31'h0000_0003, 31'h4000_0000, 1'b0); // -3 + +3 -> -0
    add_op(1'b0, 31'h3FFF_FFFF, 31'h0000_0001, 31'h0000_0000, 1'b1); // max + 1
    add_op(1'b0, 31'h0000_0001, 31'h0000_0001, 31'h0000_0002, 1'b0); // 1 + 1
    add_op(1'b0, 31'h4000_0005, 31'h4000_0007, 31'h4000_000C, 1'b0); // -5 + -7
    add_op(1'b0, 31'h7FFF_FFFF, 31'h4000_0002, 31'h4000_0001, 1'b1); // -max + -2
    add_op(1'b1, 31'h0000_0003, 31'h0000_0003, 31'h0000_0000, 1'b0); // +3 - +3
    add_op(1'b0, 31'h0000_0007, 31'h4000_000A, 31'h4000_0003, 1'b0); // +7 + -10
    add_op(1'b1, 31'h4000_000A, 31'h4000_0004, 31'h4000_0006, 1'b0); // -10 - -4
    add_idle();
    repeat (2) @(posedge clk);
    #1;
    check("add_hold", {32'd0, overflow, add_out}, {32'd0, 1'b0, 31'h4000_0006});

    // CHAR with ADDs running alongside, plus an ignored start while busy.
    char_op(30'd12977698, 1'b1,
            {6'd30,6'd30,6'd31,6'd32,6'd39,6'd37,6'd37,6'd36,6'd39,6'd38});
    add_op(1'b0, 31'h0000_0010, 31'h0000_0020, 31'h0000_0030, 1'b0);
    add_idle();
    repeat (3) @(posedge clk);
    char_op(30'd5, 1'b0, '0); // busy: ignored
    wait_char_done();

    char_op(30'd0, 1'b1, {10{6'd30}});
    wait_char_done();
    char_op(30'd1073741823, 1'b1,
            {6'd31,6'd30,6'd37,6'd33,6'd37,6'd34,6'd31,6'd38,6'd32,6'd33});
    wait_char_done();
    char_op(30'd999, 1'b1, {{7{6'd30}}, 6'd39, 6'd39, 6'd39});
    wait_char_done();

    // Reset 10 cycles into a conversion aborts it silently.
    char_op(30'd12977698, 1'b0, '0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_char_out",  {4'd0, char_out}, 64'd0);
    check("abort_add_out",   {33'd0, add_out}, 64'd0);
    repeat (40) @(posedge clk);

    // Reset wins over same-cycle starts.
    @(posedge clk); #1;
    reset = 1'b1; add_start = 1'b1; char_start = 1'b1;
    in1 = 31'h0000_0001; in2 = 31'h0000_0001; char_in = 30'd7;
    @(posedge clk); #1;
    reset = 1'b0; add_start = 1'b0; char_start = 1'b0;
    repeat (40) @(posedge clk);

    char_op(30'd9, 1'b1, {{9{6'd30}}, 6'd39});
    wait_char_done();

    for (int i = 0; i < 50 && (add_cyc_q.size() > 0 || chr_cyc_q.size() > 0); i++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mix_add_char_unit.md
# mix_add_char_unit

Arithmetic helper for the MIX CPU core. It performs MIX ADD/SUB on 31-bit sign-magnitude words with overflow detection, and MIX CHAR, which converts a 30-bit magnitude into ten MIX digit character codes. It sits beside the register file. The sequencer pulses a start strobe; the unit answers with a one-cycle stop strobe and holds the result for write-back into rA/rX.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- add_start  in  1  one-cycle strobe; samples in1, in2, subtract.
- subtract  in  1  1 = SUB (negate in2 sign before adding).
- in1  in  31  rA: bit 30 sign (1 = negative), bits 29:0 magnitude.
- in2  in  31  operand V, same format.
- add_stop  out  1  one-cycle completion strobe.
- add_out  out  31  sign-magnitude result.
- overflow  out  1  result magnitude exceeded 2^30−1; valid with add_out.
- char_start  in  1  one-cycle strobe; samples char_in.
- char_in  in  30  unsigned magnitude (rA[29:0]).
- char_stop  out  1  one-cycle completion strobe.
- char_out  out  60  ten 6-bit codes, most significant digit in bits 59:54.

## Operation
- Word format: 5 bytes × 6 bits, magnitude 0..2^30−1; sign separate.
- ADD, effective operand sign s2 = in2[30] XOR subtract:
  - Equal signs: sum = |in1| + |in2|, 31 bits wide. Sign = in1[30]. If sum ≥ 2^30: overflow = 1 and magnitude = sum − 2^30. Otherwise overflow = 0.
  - Opposite signs: magnitude = |larger| − |smaller|, with the sign of the larger operand. overflow = 0.
  - Zero result (magnitudes equal, or a wrap to exactly 0): sign = in1[30], so −0 is preserved.
- CHAR:
  - The binary magnitude is converted to 10 BCD digits by double-dabble: 30 shift iterations, adding 3 to any digit ≥ 5 before each shift. Max input 1073741823 fits in 10 digits.
  - Each digit d is emitted as code 30 + d. Leading zeros are emitted as 30.
  - char_out[59:30] goes to rA and char_out[29:0] to rX. Signs are not handled here.
- ADD and CHAR paths are independent and may run concurrently.

## Timing
- Reset values: add_stop = 0, char_stop = 0, add_out = 0, overflow = 0, char_out = 0. A CHAR conversion in progress is aborted, and no char_stop is issued for it.
- ADD latency 1:
  - add_start is sampled in cycle N; add_stop = 1 in cycle N+1 with add_out and overflow valid.
  - Results hold until the next add_start completes.
  - Back-to-back add_start every cycle is legal; each produces its own stop.
- CHAR latency 31:
  - char_start in cycle N loads the shifter. Iterations run in cycles N+1..N+30.
  - char_stop = 1 in cycle N+31, with char_out valid and held until the next completion.
  - char_start while a conversion is busy is ignored.
- Strobes are exactly one cycle wide and never asserted without a preceding start.
- Reset asserted in the same cycle as a start has priority: the start is discarded.

## Test plan
- ADD +5 + +7 (subtract = 0) → add_stop 1 cycle later; add_out = +12 (0x0000000C); overflow = 0.
- SUB +5 − +7 → add_out = {1, 30'd2}; overflow = 0. Then −3 + +3 → add_out = {1, 30'd0} (sign of in1 kept).
- ADD +(2^30−1) + +1 → add_out = {0, 30'd0}; overflow = 1. Next add of +1 + +1 → overflow = 0.
- CHAR 12977698 → char_stop exactly 31 cycles after char_start. char_out codes in order: 30,30,31,32,39,37,37,36,39,38.
- CHAR 0 → all ten codes 30. CHAR 1073741823 → codes 31,30,37,33,37,34,31,38,32,33.
- Reset 10 cycles into a CHAR → no char_stop ever appears for it; char_out = 0. A new char_start afterwards completes normally in 31 cycles.
